// File: rtl/afifo_rd_packer.sv
// Read-side drain of the async FIFO: packs FWFT bytes little-endian into words on a valid/ready port.
// Optional idle-timeout auto-flush is enabled by defining AFIFO_PACKER_TIMEOUT_EN.
module afifo_rd_packer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                                 rclk,
    input  logic                                 rrst_n,
    input  logic                                 rempty,
    input  logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 rinc,
    input  logic                                 flush,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data,
    output logic [BYTES_PER_WORD-1:0]            out_keep,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [15:0]                          word_cnt
);
    localparam int unsigned WW = DATA_WIDTH * BYTES_PER_WORD;
    localparam int unsigned CW = $clog2(BYTES_PER_WORD + 1);

    if (DATA_WIDTH != 8) begin : g_dw_check
        $error("afifo_rd_packer: DATA_WIDTH must be 8");
    end
    if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8) begin : g_bpw_check
        $error("afifo_rd_packer: BYTES_PER_WORD must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_to_check
        $error("afifo_rd_packer: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic {ACCUM, FLUSH_WAIT} state_t;

    state_t                     state;
    logic [WW-1:0]              acc;
    logic [CW-1:0]              cnt;

    logic                       load_allowed_c;
    logic                       pop_c;
    logic                       flush_req_c;
    logic                       load_c;
    logic                       go_wait_c;
    logic [WW-1:0]              acc_pop_c;
    logic [CW-1:0]              cnt_pop_c;
    logic [BYTES_PER_WORD-1:0]  keep_c;

    // Lanes below n are valid.
    function automatic logic [BYTES_PER_WORD-1:0] keep_of(input logic [CW-1:0] n);
        logic [BYTES_PER_WORD-1:0] k;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            k[i] = (CW'(i) < n);
        end
        return k;
    endfunction

    assign load_allowed_c = !out_valid || out_ready;

    // Pop only when the byte can be absorbed: the last lane needs a free output slot.
    assign pop_c = rrst_n && (state == ACCUM) && !rempty &&
                   !((cnt == CW'(BYTES_PER_WORD - 1)) && !load_allowed_c);
    assign rinc  = pop_c;

    always_comb begin
        acc_pop_c = acc;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            if (pop_c && (cnt == CW'(i))) begin
                acc_pop_c[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
            end
        end
    end

    assign cnt_pop_c = cnt + CW'(pop_c);
    assign keep_c    = keep_of(cnt_pop_c);

`ifdef AFIFO_PACKER_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        timeout_c;

    assign timeout_c = (state == ACCUM) && (cnt != '0) && !pop_c &&
                       (idle_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Idle cycles spent holding a partial word.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            idle_cnt <= '0;
        end else if (pop_c || load_c) begin
            idle_cnt <= '0;
        end else if ((state == ACCUM) && (cnt != '0)) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    assign flush_req_c = flush || timeout_c;
`else
    assign flush_req_c = flush;
`endif

    // Decide whether this cycle loads the output slot or parks in FLUSH_WAIT.
    always_comb begin
        load_c    = 1'b0;
        go_wait_c = 1'b0;
        case (state)
            ACCUM: begin
                if (cnt_pop_c == CW'(BYTES_PER_WORD)) begin
                    load_c = 1'b1;
                end else if (flush_req_c && (cnt_pop_c != '0)) begin
                    if (load_allowed_c) load_c    = 1'b1;
                    else                go_wait_c = 1'b1;
                end
            end
            FLUSH_WAIT: begin
                load_c = load_allowed_c;
            end
            default: begin
                load_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            word_cnt  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (load_c) begin
                out_valid <= 1'b1;
                out_data  <= acc_pop_c;
                out_keep  <= keep_c;
                acc       <= '0;
                cnt       <= '0;
                state     <= ACCUM;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                acc <= acc_pop_c;
                cnt <= cnt_pop_c;
                if (go_wait_c) begin
                    state <= FLUSH_WAIT;
                end
            end
        end
    end
endmodule
